// File: rtl/clause_array_ctrl.sv
// Clause array controller: sequences clause load, imply passes,
// conflict analysis and backtrack strobes for the clause array.
module clause_array_ctrl #(
  parameter int NUM_CLAUSES  = 8,
  parameter int WIDTH_CIDX   = 3,
  parameter int MAX_IMP_ITER = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start_i,
  input  logic                   load_valid_i,
  output logic                   load_ready_o,
  input  logic                   load_last_i,
  output logic [NUM_CLAUSES-1:0] wr_row_o,
  input  logic                   imply_start_i,
  input  logic                   bkt_start_i,
  input  logic                   new_imply_i,
  input  logic                   conflict_i,
  input  logic                   all_sat_i,
  input  logic                   analyze_done_i,
  output logic                   apply_imply_o,
  output logic                   apply_analyze_o,
  output logic                   apply_bkt_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [1:0]             result_o
);

  localparam int IW = (MAX_IMP_ITER > 1) ? $clog2(MAX_IMP_ITER) : 1;

  localparam logic [1:0] RES_OK   = 2'b00;
  localparam logic [1:0] RES_CONF = 2'b01;
  localparam logic [1:0] RES_SAT  = 2'b10;
  localparam logic [1:0] RES_TO   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_IMPLY,
    S_ANALYZE,
    S_BKT
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH_CIDX-1:0] row_q, row_d;
  logic [IW-1:0]         iter_q, iter_d;
  logic                  done_q, done_d;
  logic [1:0]            result_q, result_d;
  logic                  beat_acc;

  assign beat_acc = (state_q == S_LOAD) && load_valid_i;

  // State, counters and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      iter_q   <= '0;
      done_q   <= 1'b0;
      result_q <= RES_OK;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      iter_q   <= iter_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Next-state, counter updates and completion status
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    iter_d   = iter_q;
    done_d   = 1'b0;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_start_i) begin
          state_d = S_LOAD;
        end else if (bkt_start_i) begin
          state_d = S_BKT;
        end else if (imply_start_i) begin
          state_d = S_IMPLY;
        end
      end
      S_LOAD: begin
        if (beat_acc) begin
          if (load_last_i ||
              row_q == WIDTH_CIDX'(NUM_CLAUSES - 1)) begin
            state_d  = S_IDLE;
            row_d    = '0;
            done_d   = 1'b1;
            result_d = RES_OK;
          end else begin
            row_d = row_q + WIDTH_CIDX'(1);
          end
        end
      end
      S_IMPLY: begin
        if (conflict_i) begin
          state_d = S_ANALYZE;
          iter_d  = '0;
        end else if (all_sat_i) begin
          state_d  = S_IDLE;
          iter_d   = '0;
          done_d   = 1'b1;
          result_d = RES_SAT;
        end else if (!new_imply_i) begin
          state_d  = S_IDLE;
          iter_d   = '0;
          done_d   = 1'b1;
          result_d = RES_OK;
        end else if (iter_q == IW'(MAX_IMP_ITER - 1)) begin
          state_d  = S_IDLE;
          iter_d   = '0;
          done_d   = 1'b1;
          result_d = RES_TO;
        end else begin
          iter_d = iter_q + IW'(1);
        end
      end
      S_ANALYZE: begin
        if (analyze_done_i) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          result_d = RES_CONF;
        end
      end
      S_BKT: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        result_d = RES_OK;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decoded from the current state
  always_comb begin
    load_ready_o    = (state_q == S_LOAD);
    apply_imply_o   = (state_q == S_IMPLY);
    apply_analyze_o = (state_q == S_ANALYZE);
    apply_bkt_o     = (state_q == S_BKT);
    busy_o          = (state_q != S_IDLE);
    done_o          = done_q;
    result_o        = result_q;
    wr_row_o        = '0;
    for (int i = 0; i < NUM_CLAUSES; i++) begin
      wr_row_o[i] = beat_acc && (row_q == WIDTH_CIDX'(i));
    end
  end

endmodule

// File: tb/tb_clause_array_ctrl.sv
// Scoreboard bench for clause_array_ctrl: expected row strobes
// and results are queued at stimulus time, popped on DUT output.
module tb_clause_array_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start, load_valid, load_last;
  logic       imply_start, bkt_start;
  logic       new_imply, conflict, all_sat, analyze_done;
  logic       load_ready;
  logic [7:0] wr_row;
  logic       ap_imp, ap_ana, ap_bkt;
  logic       busy, done;
  logic [1:0] result;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int imp_cnt = 0;
  int ana_cnt = 0;
  int bkt_cnt = 0;

  logic [31:0] exp_wr[$];
  logic [31:0] exp_res[$];

  always #5 clk = ~clk;

  clause_array_ctrl #(
    .NUM_CLAUSES (8),
    .WIDTH_CIDX  (3),
    .MAX_IMP_ITER(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_start_i   (load_start),
    .load_valid_i   (load_valid),
    .load_ready_o   (load_ready),
    .load_last_i    (load_last),
    .wr_row_o       (wr_row),
    .imply_start_i  (imply_start),
    .bkt_start_i    (bkt_start),
    .new_imply_i    (new_imply),
    .conflict_i     (conflict),
    .all_sat_i      (all_sat),
    .analyze_done_i (analyze_done),
    .apply_imply_o  (ap_imp),
    .apply_analyze_o(ap_ana),
    .apply_bkt_o    (ap_bkt),
    .busy_o         (busy),
    .done_o         (done),
    .result_o       (result)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    imp_cnt = 0;
    ana_cnt = 0;
    bkt_cnt = 0;
  endtask

  task automatic beat(input logic last);
    load_valid = 1'b1;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < bound) begin
      tick();
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  // Output monitor: pops expectations as the DUT produces events
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_row != 0 || ap_imp || ap_ana || ap_bkt)
        chk("excl",
            {31'b0, $countones({wr_row, ap_imp, ap_ana, ap_bkt}) <= 1},
            1);
      if (wr_row != 0) begin
        if (exp_wr.size() == 0) chk("wr_spurious", {24'b0, wr_row}, 0);
        else chk("wr_row", {24'b0, wr_row}, exp_wr.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (exp_res.size() == 0) chk("done_spurious", 1, 0);
        else chk("result", {30'b0, result}, exp_res.pop_front());
      end
      if (ap_imp) imp_cnt++;
      if (ap_ana) ana_cnt++;
      if (ap_bkt) bkt_cnt++;
    end
  end

  initial begin
    rst = 1'b1;
    load_start = 0; load_valid = 0; load_last = 0;
    imply_start = 0; bkt_start = 0;
    new_imply = 0; conflict = 0; all_sat = 0; analyze_done = 0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_ready", {31'b0, load_ready}, 0);
    chk("rst_strb", {21'b0, wr_row, ap_imp, ap_ana, ap_bkt}, 0);
    chk("rst_res", {30'b0, result}, 0);

    // Full 8-row load with no last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_ready", {31'b0, load_ready}, 1);
    exp_res.push_back(32'h0);
    for (int i = 0; i < 8; i++) begin
      exp_wr.push_back(32'h1 << i);
      beat(1'b0);
    end
    wait_done(4);
    chk("load_exit", {31'b0, load_ready}, 0);

    // Early last on the third beat, then a fresh load from row 0
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    exp_res.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      exp_wr.push_back(32'h1 << i);
      beat(i == 2);
    end
    wait_done(4);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    exp_res.push_back(32'h0);
    exp_wr.push_back(32'h1);
    beat(1'b1);
    wait_done(4);

    // Imply goes quiescent after 3 productive cycles
    clr_cnt();
    exp_res.push_back(32'h0);
    new_imply = 1'b1;
    imply_start = 1'b1;
    tick();
    imply_start = 1'b0;
    repeat (3) tick();
    new_imply = 1'b0;
    tick();
    wait_done(4);
    chk("imp_quiet_len", imp_cnt, 4);

    // Imply never settles: timeout
    clr_cnt();
    exp_res.push_back(32'h3);
    new_imply = 1'b1;
    imply_start = 1'b1;
    tick();
    imply_start = 1'b0;
    wait_done(40);
    new_imply = 1'b0;
    chk("imp_to_len", imp_cnt, 16);

    // Conflict beats all_sat in cycle 2, analysis takes 6 cycles
    clr_cnt();
    exp_res.push_back(32'h1);
    new_imply = 1'b1;
    imply_start = 1'b1;
    tick();
    imply_start = 1'b0;
    repeat (2) tick();
    conflict = 1'b1;
    all_sat = 1'b1;
    tick();
    conflict = 1'b0;
    all_sat = 1'b0;
    new_imply = 1'b0;
    repeat (5) tick();
    analyze_done = 1'b1;
    tick();
    analyze_done = 1'b0;
    wait_done(4);
    chk("ana_imp_len", imp_cnt, 3);
    chk("ana_len", ana_cnt, 6);

    // All starts at once: load wins; starts while busy are dropped
    clr_cnt();
    load_start = 1'b1;
    bkt_start = 1'b1;
    imply_start = 1'b1;
    tick();
    load_start = 1'b0;
    bkt_start = 1'b0;
    chk("prio_load", {31'b0, load_ready}, 1);
    tick();
    imply_start = 1'b0;
    exp_res.push_back(32'h0);
    exp_wr.push_back(32'h1);
    beat(1'b0);
    exp_wr.push_back(32'h2);
    beat(1'b1);
    wait_done(4);
    repeat (3) tick();
    chk("prio_no_imply", imp_cnt, 0);
    chk("prio_no_bkt", bkt_cnt, 0);

    // Single backtrack strobe
    exp_res.push_back(32'h0);
    bkt_start = 1'b1;
    tick();
    bkt_start = 1'b0;
    wait_done(4);
    chk("bkt_len", bkt_cnt, 1);

    // all_sat ends imply immediately
    clr_cnt();
    exp_res.push_back(32'h2);
    new_imply = 1'b1;
    all_sat = 1'b1;
    imply_start = 1'b1;
    tick();
    imply_start = 1'b0;
    tick();
    all_sat = 1'b0;
    wait_done(4);
    chk("sat_len", imp_cnt, 1);
    chk("sat_hold", {30'b0, result}, 2);

    // Reset in imply cycle 2 aborts silently
    begin
      int d0;
      d0 = done_cnt;
      imply_start = 1'b1;
      tick();
      imply_start = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      new_imply = 1'b0;
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_done", {31'b0, done}, 0);
      chk("abort_strb", {21'b0, wr_row, ap_imp, ap_ana, ap_bkt}, 0);
      chk("abort_res", {30'b0, result}, 0);
      repeat (3) tick();
      chk("abort_no_done", done_cnt, d0);
    end

    chk("wr_q_empty", exp_wr.size(), 0);
    chk("res_q_empty", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clause_array_ctrl.md
CLAUSE_ARRAY_CTRL -- requirements
Module: clause_array_ctrl

Interface
REQ-001 SHALL have parameter NUM_CLAUSES, default 8: number of clause rows in the array.
REQ-002 SHALL have parameter WIDTH_CIDX, default 3: row index width, with 2^WIDTH_CIDX >= NUM_CLAUSES.
REQ-003 SHALL have parameter MAX_IMP_ITER, default 16: maximum cycles spent in one imply pass.
REQ-004 SHALL have one clock and synchronous active-high reset: clk input 1, rise-edge clock; rst input 1, synchronous, active-high.
REQ-005 SHALL have load_start_i input 1: begin clause load.
REQ-006 SHALL have load_valid_i input 1 and load_ready_o output 1: clause-row handshake.
REQ-007 SHALL have load_last_i input 1: current beat is the final row.
REQ-008 SHALL have wr_row_o output NUM_CLAUSES: one-hot row write strobe, driving wr_i of the row's lit cells.
REQ-009 SHALL have imply_start_i and bkt_start_i inputs, 1 bit each: command requests.
REQ-010 SHALL have new_imply_i, conflict_i and all_sat_i inputs, 1 bit each: array OR-reduced status (any first_imply, any conflict, all clauses csat).
REQ-011 SHALL have analyze_done_i input 1: conflict analyser finished.
REQ-012 SHALL have apply_imply_o, apply_analyze_o and apply_bkt_o outputs, 1 bit each: array control strobes.
REQ-013 SHALL have busy_o output 1, done_o output 1 and result_o output 2: status.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, IMPLY, ANALYZE, BKT; busy_o=1 in every state except IDLE.
REQ-015 In IDLE, start priority SHALL be load_start_i > bkt_start_i > imply_start_i; a start is taken in the cycle it is sampled, and lower-priority starts that cycle are dropped.
REQ-016 LOAD SHALL assert load_ready_o=1; each cycle with load_valid_i&load_ready_o SHALL assert wr_row_o one-hot at row counter value, combinationally in that cycle, and increment the counter.
REQ-017 LOAD SHALL exit to IDLE after the accepted beat with load_last_i=1 or the beat at row NUM_CLAUSES-1, whichever comes first, pulsing done_o with result_o=2'b00; the row counter clears on exit.
REQ-018 wr_row_o SHALL be all-zero whenever no beat is accepted.
REQ-019 IMPLY SHALL assert apply_imply_o every cycle in state and count cycles in an iteration counter starting at 0.
REQ-020 Each IMPLY cycle SHALL evaluate in order: conflict_i -> ANALYZE; else all_sat_i -> IDLE with done_o, result 2'b10; else new_imply_i=0 -> IDLE with done_o, result 2'b00 (quiescent); else counter=MAX_IMP_ITER-1 -> IDLE with done_o, result 2'b11 (timeout); else stay.
REQ-021 ANALYZE SHALL hold apply_analyze_o=1 until analyze_done_i=1, then go to IDLE with done_o, result 2'b01; apply_analyze_o drops in the cycle after done.
REQ-022 BKT SHALL assert apply_bkt_o for exactly one cycle, then return to IDLE with done_o, result 2'b00.
REQ-023 done_o SHALL be a one-cycle pulse, registered, asserted the cycle after the exiting transition; result_o SHALL be registered with done_o and hold until the next done_o.
REQ-024 At most one of apply_imply_o, apply_analyze_o, apply_bkt_o and any wr_row_o bit SHALL be high in any cycle.
REQ-025 Start inputs received while busy_o=1 SHALL be ignored and not queued.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, clear counters, and drive all outputs to 0 (result_o=2'b00) on the following cycle.
REQ-027 Reset mid-operation SHALL abort without a done_o pulse; no wr_row_o or apply strobe SHALL be high in the cycle after reset.

Verification
REQ-028 Load case: load_start, then 8 valid beats with no last -> wr_row_o = 0x01,0x02,...,0x80 on consecutive beats, then done_o with result 00.
REQ-029 Early last: beat 3 with load_last_i=1 -> rows 0x01,0x02,0x04 are written; LOAD exits; next load starts at row 0x01.
REQ-030 Imply case: new_imply_i=1 for 3 cycles then 0 -> apply_imply_o high for 4 cycles, done_o with result 00; with new_imply_i held 1 -> 16 cycles, result 11.
REQ-031 Conflict and all_sat together in cycle 2 -> ANALYZE; hold analyze_done_i=0 for 5 cycles -> apply_analyze_o high 6 cycles, result 01.
REQ-032 load_start, bkt_start and imply_start in the same IDLE cycle -> LOAD taken; later bkt -> single-cycle apply_bkt_o, result 00.
REQ-033 rst during IMPLY cycle 2 -> next cycle all outputs 0, no done_o, busy_o=0.
